// File: rtl/csr_unit.sv
// Machine-mode CSR unit: sparse CSR file, atomic RW/RS/RC commit, trap entry/return.
// Optional 64-bit cycle/instret counters are built when CSR_COUNTERS_EN is defined.
module csr_unit #(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_rdata,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_wb_addr,
  input  logic [XLEN-1:0] csr_wb_data,
  output logic            csr_illegal,
  input  logic            instr_retire,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] epc,
  output logic            irq_pending
);
  localparam logic [11:0] A_MSTATUS  = 12'h300, A_MISA    = 12'h301, A_MIE    = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305, A_MSCRATCH = 12'h340, A_MEPC  = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342, A_MTVAL   = 12'h343, A_MIP    = 12'h344;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [11:0] A_MCYCLE   = 12'hB00, A_MCYCLEH = 12'hB80;
  localparam logic [11:0] A_MINSTRET = 12'hB02, A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00, A_CYCLEH  = 12'hC80;
  localparam logic [11:0] A_INSTRET  = 12'hC02, A_INSTRETH = 12'hC82;
  localparam logic [1:0]  OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;
  localparam logic [XLEN-1:0] MIE_MASK = 32'h0000_0888;
  localparam logic [XLEN-1:0] MISA_VAL = 32'h4000_0100;

  logic            st_mie, st_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mip_w, mstatus_w, tvec_base, wb_old, wval;
  logic            rd_unused_impl, wb_impl, writes_req, wr_en, unused_bits;
`ifdef CSR_COUNTERS_EN
  logic [63:0]     mcycle_q, minstret_q, mcycle_nx, minstret_nx;
`endif

  assign mip_w     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};
  assign mstatus_w = {24'b0, st_mpie, 3'b0, st_mie, 3'b0};

  // Returns {implemented, value}; shared by the read port and the RS/RC old-value path.
  function automatic logic [XLEN:0] csr_read(input logic [11:0] a);
    logic [XLEN:0] r;
    case (a)
      A_MSTATUS:  r = {1'b1, mstatus_w};
      A_MISA:     r = {1'b1, MISA_VAL};
      A_MIE:      r = {1'b1, mie_q};
      A_MTVEC:    r = {1'b1, mtvec_q};
      A_MSCRATCH: r = {1'b1, mscratch_q};
      A_MEPC:     r = {1'b1, mepc_q};
      A_MCAUSE:   r = {1'b1, mcause_q};
      A_MTVAL:    r = {1'b1, mtval_q};
      A_MIP:      r = {1'b1, mip_w};
      A_MHARTID:  r = {1'b1, HART_ID};
`ifdef CSR_COUNTERS_EN
      A_MCYCLE,   A_CYCLE:    r = {1'b1, mcycle_q[31:0]};
      A_MCYCLEH,  A_CYCLEH:   r = {1'b1, mcycle_q[63:32]};
      A_MINSTRET, A_INSTRET:  r = {1'b1, minstret_q[31:0]};
      A_MINSTRETH, A_INSTRETH: r = {1'b1, minstret_q[63:32]};
`endif
      default:    r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    {rd_unused_impl, csr_rdata} = csr_read(csr_addr);
    {wb_impl, wb_old}           = csr_read(csr_wb_addr);
    // RS/RC with a zero operand is a pure read, so it may target read-only space.
    writes_req  = (csr_op == OP_RW) || (csr_wb_data != '0);
    csr_illegal = (csr_op != OP_NONE) &&
                  (!wb_impl || ((csr_wb_addr[11:10] == 2'b11) && writes_req));
    case (csr_op)
      OP_RS:   wval = wb_old | csr_wb_data;
      OP_RC:   wval = wb_old & ~csr_wb_data;
      default: wval = csr_wb_data;
    endcase
    wr_en = (csr_op != OP_NONE) && writes_req && !csr_illegal && !trap_valid && !mret;
  end

`ifdef CSR_COUNTERS_EN
  // A software write to either half replaces the increment for the whole counter.
  always_comb begin
    mcycle_nx   = mcycle_q + 64'd1;
    minstret_nx = minstret_q + {63'b0, instr_retire};
    if (wr_en && csr_wb_addr == A_MCYCLE)    mcycle_nx   = {mcycle_q[63:32], wval};
    if (wr_en && csr_wb_addr == A_MCYCLEH)   mcycle_nx   = {wval, mcycle_q[31:0]};
    if (wr_en && csr_wb_addr == A_MINSTRET)  minstret_nx = {minstret_q[63:32], wval};
    if (wr_en && csr_wb_addr == A_MINSTRETH) minstret_nx = {wval, minstret_q[31:0]};
  end
`endif

  assign tvec_base   = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_target = (mtvec_q[1:0] == 2'b01 && trap_cause[XLEN-1])
                       ? tvec_base + {trap_cause[XLEN-3:0], 2'b00} : tvec_base;
  assign epc         = {mepc_q[XLEN-1:2], 2'b00};
  assign irq_pending = st_mie && |(mip_w & mie_q);
  assign unused_bits = trap_cause[XLEN-2] ^ instr_retire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= '0;
      minstret_q <= '0;
`endif
    end else begin
      if (trap_valid) begin
        mepc_q   <= trap_pc;
        mcause_q <= trap_cause;
        mtval_q  <= trap_val;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr_en) begin
        case (csr_wb_addr)
          A_MSTATUS:  begin st_mie <= wval[3]; st_mpie <= wval[7]; end
          A_MIE:      mie_q      <= wval & MIE_MASK;
          A_MTVEC:    mtvec_q    <= {wval[XLEN-1:2], (wval[1:0] == 2'b01) ? 2'b01 : 2'b00};
          A_MSCRATCH: mscratch_q <= wval;
          A_MEPC:     mepc_q     <= wval;
          A_MCAUSE:   mcause_q   <= wval;
          A_MTVAL:    mtval_q    <= wval;
          default:    ;
        endcase
      end
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= mcycle_nx;
      minstret_q <= minstret_nx;
`endif
    end
  end
endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed plan plus random traffic against a map-based CSR model.
// Counter checks follow CSR_COUNTERS_EN when the bench is built with it.
module tb_csr_unit;
  localparam logic [31:0] HART = 32'h0000_0003;
  localparam logic [31:0] MTVR = 32'h0000_1000;
  localparam int OW = 98;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr, csr_wb_addr;
  logic [31:0] csr_rdata, csr_wb_data, trap_cause, trap_pc, trap_val, trap_target, epc;
  logic [1:0]  csr_op;
  logic        csr_illegal, instr_retire, irq_ext, irq_timer, irq_soft, trap_valid, mret, irq_pending;

  always #5 clk = ~clk;

  csr_unit #(.XLEN(32), .HART_ID(HART), .MTVEC_RESET(MTVR)) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_op(csr_op),
    .csr_wb_addr(csr_wb_addr), .csr_wb_data(csr_wb_data), .csr_illegal(csr_illegal),
    .instr_retire(instr_retire), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
    .mret(mret), .trap_target(trap_target), .epc(epc), .irq_pending(irq_pending));

  typedef struct packed {
    logic [31:0] rdata; logic ill; logic [31:0] tgt; logic [31:0] epc; logic irq;
  } obs_t;

  typedef struct {
    logic [11:0] ra; logic [1:0] op; logic [11:0] wa; logic [31:0] wd;
    logic ret, ie, it, is, tv, mr; logic [31:0] tc, tp, tval;
  } stim_t;

  logic [OW-1:0] exp_q[$];
  logic [11:0]   tag_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  stim_t         s;

  // Reference model: implemented CSRs live in an associative map keyed by address.
  logic [31:0] m_csr[int];
  logic [63:0] m_cyc, m_ret;

  function automatic void m_reset();
    m_csr.delete();
    m_csr['h300] = 0; m_csr['h301] = 32'h4000_0100; m_csr['h304] = 0; m_csr['h305] = MTVR;
    m_csr['h340] = 0; m_csr['h341] = 0; m_csr['h342] = 0; m_csr['h343] = 0; m_csr['hF14] = HART;
    m_cyc = 0; m_ret = 0;
  endfunction

  function automatic logic [31:0] m_mip();
    return (32'(s.ie) << 11) | (32'(s.it) << 7) | (32'(s.is) << 3);
  endfunction

  function automatic bit m_is_counter(int a);
`ifdef CSR_COUNTERS_EN
    return a inside {'hB00, 'hB80, 'hB02, 'hB82, 'hC00, 'hC80, 'hC02, 'hC82};
`else
    return (a < 0);
`endif
  endfunction

  function automatic logic [31:0] m_read(int a);
    if (a == 'h344) return m_mip();
    if (m_is_counter(a)) begin
      if (a % 'h80 == 0) return (a >= 'hB80 && a != 'hC00) ? m_cyc[63:32] : m_cyc[31:0];
      return (a == 'hB82 || a == 'hC82) ? m_ret[63:32] : m_ret[31:0];
    end
    if (m_csr.exists(a)) return m_csr[a];
    return 0;
  endfunction

  function automatic bit m_illegal(int op, int a, logic [31:0] d);
    bit impl;
    impl = m_csr.exists(a) || a == 'h344 || m_is_counter(a);
    return op != 0 && (!impl || (a >= 'hC00 && (op == 1 || d != 0)));
  endfunction

  function automatic logic [31:0] m_mask(int a);
    case (a)
      'h300: return 32'h88;
      'h304: return 32'h888;
      'h301, 'h344, 'hF14: return 0;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic void m_commit();
    logic [31:0] old, nv, st;
    bit wc, wr;
    wc = 0; wr = 0;
    st = m_csr['h300];
    if (s.tv) begin
      m_csr['h341] = s.tp; m_csr['h342] = s.tc; m_csr['h343] = s.tval;
      m_csr['h300] = st[3] ? 32'h80 : 32'h0;
    end else if (s.mr) begin
      m_csr['h300] = 32'h80 | (st[7] ? 32'h08 : 32'h0);
    end else if (s.op != 0 && !m_illegal(s.op, s.wa, s.wd) && (s.op == 1 || s.wd != 0)) begin
      old = m_read(s.wa);
      nv = (s.op == 1) ? s.wd : (s.op == 2) ? (old | s.wd) : (old & ~s.wd);
      if (s.wa == 'h305 && nv[1]) nv = nv & 32'hFFFF_FFFC;
      if (m_is_counter(s.wa)) begin
        case (s.wa)
          'hB00: begin m_cyc[31:0]  = nv; wc = 1; end
          'hB80: begin m_cyc[63:32] = nv; wc = 1; end
          'hB02: begin m_ret[31:0]  = nv; wr = 1; end
          'hB82: begin m_ret[63:32] = nv; wr = 1; end
          default: ;
        endcase
      end else if (m_csr.exists(s.wa)) begin
        m_csr[s.wa] = (old & ~m_mask(s.wa)) | (nv & m_mask(s.wa));
      end
    end
    if (!wc) m_cyc = m_cyc + 1;
    if (!wr && s.ret) m_ret = m_ret + 1;
  endfunction

  function automatic void push_exp();
    obs_t e;
    logic [31:0] mt, base;
    mt   = m_csr['h305];
    base = mt & 32'hFFFF_FFFC;
    e.rdata = m_read(s.ra);
    e.ill   = m_illegal(s.op, s.wa, s.wd);
    e.tgt   = (mt[1:0] == 2'b01 && s.tc[31]) ? base + 4 * (s.tc & 32'h7FFF_FFFF) : base;
    e.epc   = m_csr['h341] & 32'hFFFF_FFFC;
    e.irq   = m_csr['h300][3] && ((m_mip() & m_csr['h304]) != 0);
    exp_q.push_back(e);
    tag_q.push_back(s.ra);
  endfunction

  // Monitor: compares every observation pushed at a falling edge, 2 time units later.
  always @(negedge clk) begin
    obs_t e, g;
    logic [11:0] t;
    #2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = {csr_rdata, csr_illegal, trap_target, epc, irq_pending};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL csr_obs ra=%h: got rdata=%h ill=%b tgt=%h epc=%h irq=%b, expected rdata=%h ill=%b tgt=%h epc=%h irq=%b",
                 t, g.rdata, g.ill, g.tgt, g.epc, g.irq, e.rdata, e.ill, e.tgt, e.epc, e.irq);
      end
    end
  end

  task automatic drive();
    csr_addr = s.ra; csr_op = s.op; csr_wb_addr = s.wa; csr_wb_data = s.wd;
    instr_retire = s.ret; irq_ext = s.ie; irq_timer = s.it; irq_soft = s.is;
    trap_valid = s.tv; trap_cause = s.tc; trap_pc = s.tp; trap_val = s.tval; mret = s.mr;
  endtask

  task automatic idle_s();
    s = '{ra: 12'h0, op: 2'b0, wa: 12'h0, wd: 32'h0, ret: 1'b0, ie: 1'b0, it: 1'b0, is: 1'b0,
          tv: 1'b0, mr: 1'b0, tc: 32'h0, tp: 32'h0, tval: 32'h0};
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step();
    drive();
    push_exp();
    @(posedge clk);
    m_commit();
    @(negedge clk);
  endtask

  task automatic do_op(input logic [11:0] ra, input logic [1:0] op, input logic [11:0] wa,
                       input logic [31:0] wd);
    idle_s();
    s.ra = ra; s.op = op; s.wa = wa; s.wd = wd;
    step();
  endtask

  // Asynchronous reset asserted between edges while the current inputs stay active.
  task automatic do_reset();
    drive();
    #2 rst = 1'b0;
    m_reset();
    @(negedge clk);
    push_exp();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_s();
    logic [11:0] pool[20];
    pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
             12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
             12'h7C0, 12'h000};
    s.ra = pool[$urandom_range(0, 19)];
    s.wa = pool[$urandom_range(0, 19)];
    if (s.wa == 12'h000) s.wa = 12'($urandom);
    s.op = 2'($urandom_range(0, 3));
    s.wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    s.ret = 1'($urandom); s.ie = 1'($urandom); s.it = 1'($urandom); s.is = 1'($urandom);
    s.tv = ($urandom_range(0, 15) == 0); s.mr = ($urandom_range(0, 15) == 0);
    s.tc = $urandom; s.tp = $urandom; s.tval = $urandom;
  endtask

  initial begin
    idle_s();
    rst = 1'b0;
    drive();
    @(negedge clk);
    s.ra = 12'h305;
    do_reset();
    // Reset values
    do_op(12'h305, 2'b00, 12'h000, 0);
    do_op(12'h300, 2'b00, 12'h000, 0);
    do_op(12'hF14, 2'b00, 12'h000, 0);
    do_op(12'h301, 2'b00, 12'h000, 0);
    // mscratch RW / RS / RC
    do_op(12'h340, 2'b01, 12'h340, 32'hA5A5_0000);
    do_op(12'h340, 2'b10, 12'h340, 32'h0000_00FF);
    do_op(12'h340, 2'b11, 12'h340, 32'hA500_0000);
    do_op(12'h340, 2'b00, 12'h000, 0);
    // Illegal and read-only cases
    do_op(12'hF14, 2'b01, 12'hF14, 32'h1234_5678);
    do_op(12'hF14, 2'b10, 12'hF14, 0);
    do_op(12'hF14, 2'b00, 12'h7C0, 0);
    do_op(12'hF14, 2'b01, 12'h7C0, 32'h5);
    do_op(12'h344, 2'b01, 12'h344, 32'hFFFF_FFFF);
    do_op(12'h305, 2'b01, 12'h305, 32'h0000_0013);
    // Vectored trap and return
    do_op(12'h300, 2'b01, 12'h300, 32'h8);
    do_op(12'h305, 2'b01, 12'h305, 32'h8000_0001);
    idle_s(); s.ra = 12'h300; s.tv = 1; s.tc = 32'h8000_0007; s.tp = 32'h100; s.tval = 32'hDEAD;
    step();
    do_op(12'h341, 2'b00, 12'h000, 0);
    do_op(12'h300, 2'b00, 12'h000, 0);
    idle_s(); s.ra = 12'h300; s.mr = 1;
    step();
    do_op(12'h300, 2'b00, 12'h000, 0);
    // trap beats mret beats csr write
    idle_s(); s.ra = 12'h340; s.tv = 1; s.mr = 1; s.op = 2'b01; s.wa = 12'h340; s.wd = 32'h1234;
    s.tc = 32'h0000_0002; s.tp = 32'h200;
    step();
    do_op(12'h340, 2'b00, 12'h000, 0);
    // Interrupt pending
    do_op(12'h304, 2'b01, 12'h304, 32'hFFFF_FFFF);
    do_op(12'h300, 2'b01, 12'h300, 32'h8);
    idle_s(); s.ra = 12'h344; s.it = 1; step();
    idle_s(); s.ra = 12'h344; s.ie = 1; s.is = 1; step();
`ifdef CSR_COUNTERS_EN
    do_op(12'hB80, 2'b01, 12'hB00, 32'hFFFF_FFFF);
    do_op(12'hB80, 2'b00, 12'h000, 0);
    do_op(12'hB80, 2'b00, 12'h000, 0);
    do_op(12'hC00, 2'b01, 12'hC00, 32'h1);
    do_op(12'hB02, 2'b01, 12'hB02, 0);
    do_op(12'hB82, 2'b01, 12'hB82, 0);
    for (int i = 0; i < 3; i++) begin
      idle_s(); s.ra = 12'hB02; s.ret = 1; step();
    end
    do_op(12'hB02, 2'b00, 12'h000, 0);
`else
    do_op(12'hB00, 2'b10, 12'hB00, 32'h1);
    do_op(12'hB00, 2'b01, 12'hB00, 0);
`endif
    // Random traffic with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      rand_s();
      if (i == 200) do_reset();
      else step();
    end
    #5;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked observations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode control-and-status register unit for the RV32 core, replacing the flat 4096-entry CSR array with a sparse set of implemented CSRs. Supports atomic CSRRW/CSRRS/CSRRC, 64-bit cycle/retire counters, and trap entry/return (mepc, mcause, mtval, mstatus.MIE/MPIE). Sits beside the register file: decode supplies the read address and the op, writeback commits the op, and the trap controller drives trap and mret.

## Interface
- XLEN, 32: data width; only 32 is supported.
- HART_ID, 0: value returned by mhartid (0xF14).
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- csr_addr  in  12  read address; combinational read.
- csr_rdata  out  XLEN  read data for csr_addr; 0 if not implemented.
- csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear).
- csr_wb_addr  in  12  commit address.
- csr_wb_data  in  XLEN  rs1 value or zero-extended uimm.
- csr_illegal  out  1  combinational: csr_op!=00 and (csr_wb_addr not implemented, or addr[11:10]==2'b11 and the op writes).
- instr_retire  in  1  one instruction retired this cycle.
- irq_ext, irq_timer, irq_soft  in  1 each  level interrupt lines, reflected in mip bits 11, 7, 3.
- trap_valid  in  1  take trap this cycle.
- trap_cause  in  XLEN  mcause value; bit 31 = interrupt.
- trap_pc, trap_val  in  XLEN  written to mepc and mtval.
- mret  in  1  return from trap.
- trap_target  out  XLEN  handler address.
- epc  out  XLEN  current mepc, with bits [1:0] forced to 0.
- irq_pending  out  1  mstatus.MIE and |(mip & mie).

## Operation
- Implemented CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7; all other bits read 0), misa 0x301 (read-only, 32'h4000_0100), mie 0x304 (bits 11, 7, 3 writable), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (read-only; writes ignored without illegal), mhartid 0xF14. Counters per Configuration.
- Write value: RW gives d; RS gives old|d; RC gives old&~d. RS/RC with d==0 write nothing and are never illegal on read-only addresses.
- An illegal op commits nothing.
- Trap: mepc<=trap_pc, mcause<=trap_cause, mtval<=trap_val, MPIE<=MIE, MIE<=0.
- mret: MIE<=MPIE, MPIE<=1.
- trap_target: mtvec[1:0]==01 and trap_cause[31] gives {mtvec[31:2],2'b00}+4*trap_cause[30:0]; otherwise {mtvec[31:2],2'b00}. mtvec[1:0] values 10/11 are written as 00.
- Same-cycle priority: trap_valid > mret > csr_op. The lower-priority event is dropped entirely.

## Timing
- Reads are combinational. A write is visible on csr_rdata from the cycle after the commit edge; there is no internal bypass.
- Reset values: mstatus 0, mie 0, mtvec MTVEC_RESET, mscratch/mepc/mcause/mtval 0, counters 0. Outputs follow from these: irq_pending 0, epc 0, csr_illegal depends only on inputs.
- Reset asserted mid-operation clears all state immediately, whatever the inputs are doing.

## Configuration
- CSR_COUNTERS_EN defined:
  - mcycle 0xB00/mcycleh 0xB80 increment every cycle; minstret 0xB02/minstreth 0xB82 increment when instr_retire=1.
  - Read-only shadows: cycle 0xC00/0xC80, instret 0xC02/0xC82.
  - Counters are 64-bit, and the carry from the low half goes into the high half in the same cycle.
  - A CSR write to either half replaces that cycle's increment for the whole counter: the written half takes the new value and the other half holds.
  - All-ones wraps to 0.
- CSR_COUNTERS_EN undefined: no counter registers. Those addresses are unimplemented: they read 0 and any op on them asserts csr_illegal.

## Test plan
- Reset: hold rst=0, then release. mtvec reads MTVEC_RESET, mstatus 0, mhartid HART_ID, misa 32'h4000_0100.
- RW mscratch 0xA5A5_0000, then RS 0x0000_00FF, then RC 0xA500_0000. The reads give 0xA5A5_0000, 0xA5A5_00FF, 0x00A5_00FF.
- Illegal ops:
  - RW to 0xF14 asserts csr_illegal and mhartid is unchanged.
  - RS with d=0 to 0xF14 does not assert csr_illegal.
  - RW to 0x7C0 asserts csr_illegal.
- Vectored trap and return: set mstatus.MIE=1 and mtvec=0x8000_0001. A trap with cause 0x8000_0007 and pc 0x100 gives trap_target 0x8000_001C, mepc 0x100, and MIE=0 with MPIE=1. A following mret gives MIE=1 and epc 0x100.
- Priority: trap_valid, mret and an RW to mscratch all in one cycle. Only the trap takes effect and mscratch is unchanged.
- With CSR_COUNTERS_EN: write mcycle=0xFFFF_FFFF, then check mcycleh increments to 1 two cycles later. Pulse instr_retire 3 times and check minstret=3. Without the macro: a read of 0xB00 gives 0 and asserts csr_illegal.
